// File: rtl/cable_launch_sequencer.sv
// Cable/hook game-flow sequencer: swing, extend, weight-paced retract, deposit and cooldown.
// Build option: define CABLE_AUTO_FIRE_EN to auto-launch after an idle swing period (attract mode).
module cable_launch_sequencer #(
   parameter int MAX_EXTEND_FRAMES = 60,
   parameter int COOLDOWN_FRAMES   = 8,
   parameter int WEIGHT_W          = 3,
   parameter int VALUE_W           = 8,
   parameter int AUTO_FIRE_FRAMES  = 90
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                startOfFrame,
   input  logic                fire_btn,
   input  logic                isInCircular,
   input  logic                hit_object,
   input  logic                hit_border,
   input  logic [WEIGHT_W-1:0] object_weight,
   input  logic [VALUE_W-1:0]  object_value,
   output logic                launch_Cable,
   output logic                collision,
   output logic                frame_en,
   output logic                grabbed,
   output logic                deposit_pulse,
   output logic [VALUE_W-1:0]  deposit_value,
   output logic [2:0]          seq_state
);
   typedef enum logic [2:0] {
      SWING    = 3'd0,
      EXTEND   = 3'd1,
      RETRACT  = 3'd2,
      DEPOSIT  = 3'd3,
      COOLDOWN = 3'd4
   } state_t;

   // One frame counter is shared by every state and cleared on each state change.
   localparam int MAX_A   = (MAX_EXTEND_FRAMES > COOLDOWN_FRAMES) ? MAX_EXTEND_FRAMES : COOLDOWN_FRAMES;
   localparam int MAX_B   = (AUTO_FIRE_FRAMES > (1 << WEIGHT_W)) ? AUTO_FIRE_FRAMES : (1 << WEIGHT_W);
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(MAX_EXTEND_FRAMES - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
`ifdef CABLE_AUTO_FIRE_EN
   localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_FIRE_FRAMES - 1);
`endif

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [WEIGHT_W-1:0] weight_reg, weight_next;
   logic [VALUE_W-1:0]  value_reg, value_next;
   logic [VALUE_W-1:0]  deposit_value_reg, deposit_value_next;
   logic                fire_d_reg, circ_d_reg;
   logic                launch_reg, launch_next;
   logic                collision_reg, collision_next;
   logic                frame_en_reg, frame_en_next;
   logic                grabbed_reg, grabbed_next;
   logic                deposit_reg, deposit_next;
   logic                fire_rise, circ_rise;

   assign fire_rise = fire_btn & ~fire_d_reg;
   assign circ_rise = isInCircular & ~circ_d_reg;

   always_comb begin
      state_next         = state_reg;
      cnt_next           = cnt_reg;
      weight_next        = weight_reg;
      value_next         = value_reg;
      deposit_value_next = deposit_value_reg;
      grabbed_next       = grabbed_reg;
      launch_next        = 1'b0;
      collision_next     = 1'b0;
      frame_en_next      = 1'b0;
      deposit_next       = 1'b0;
      case (state_reg)
         SWING: begin
            frame_en_next = startOfFrame;
            if (fire_rise) begin
               cnt_next = '0;
               if (isInCircular) begin
                  launch_next = 1'b1;
                  state_next  = EXTEND;
               end
            end
`ifdef CABLE_AUTO_FIRE_EN
            else if (isInCircular && startOfFrame) begin
               if (cnt_reg == AUTO_LAST) begin
                  launch_next = 1'b1;
                  state_next  = EXTEND;
                  cnt_next    = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
`endif
         end
         EXTEND: begin
            frame_en_next = startOfFrame;
            if (hit_object) begin
               collision_next = 1'b1;
               grabbed_next   = 1'b1;
               weight_next    = object_weight;
               value_next     = object_value;
               state_next     = RETRACT;
               cnt_next       = '0;
            end else if (hit_border || (startOfFrame && cnt_reg == EXT_LAST)) begin
               // An empty cable comes back at full speed.
               collision_next = 1'b1;
               grabbed_next   = 1'b0;
               weight_next    = '0;
               state_next     = RETRACT;
               cnt_next       = '0;
            end else if (startOfFrame) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RETRACT: begin
            if (startOfFrame) begin
               if (cnt_reg == CNT_W'(weight_reg)) begin
                  frame_en_next = 1'b1;
                  cnt_next      = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            if (circ_rise) begin
               cnt_next = '0;
               if (grabbed_reg) begin
                  state_next         = DEPOSIT;
                  deposit_next       = 1'b1;
                  deposit_value_next = value_reg;
                  grabbed_next       = 1'b0;
               end else begin
                  state_next = COOLDOWN;
               end
            end
         end
         DEPOSIT: begin
            state_next = COOLDOWN;
            cnt_next   = '0;
         end
         COOLDOWN: begin
            frame_en_next = startOfFrame;
            if (COOLDOWN_FRAMES == 0) begin
               state_next = SWING;
               cnt_next   = '0;
            end else if (startOfFrame) begin
               if (cnt_reg == COOL_LAST) begin
                  state_next = SWING;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = SWING;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg         <= SWING;
         cnt_reg           <= '0;
         weight_reg        <= '0;
         value_reg         <= '0;
         deposit_value_reg <= '0;
         fire_d_reg        <= 1'b0;
         circ_d_reg        <= 1'b0;
         launch_reg        <= 1'b0;
         collision_reg     <= 1'b0;
         frame_en_reg      <= 1'b0;
         grabbed_reg       <= 1'b0;
         deposit_reg       <= 1'b0;
      end else begin
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         weight_reg        <= weight_next;
         value_reg         <= value_next;
         deposit_value_reg <= deposit_value_next;
         fire_d_reg        <= fire_btn;
         circ_d_reg        <= isInCircular;
         launch_reg        <= launch_next;
         collision_reg     <= collision_next;
         frame_en_reg      <= frame_en_next;
         grabbed_reg       <= grabbed_next;
         deposit_reg       <= deposit_next;
      end
   end

   assign launch_Cable  = launch_reg;
   assign collision     = collision_reg;
   assign frame_en      = frame_en_reg;
   assign grabbed       = grabbed_reg;
   assign deposit_pulse = deposit_reg;
   assign deposit_value = deposit_value_reg;
   assign seq_state     = state_reg;

endmodule

// File: tb/tb_cable_launch_sequencer.sv
// Bench for cable_launch_sequencer: directed game episodes then random play, every cycle
// compared against a frame-counting reference model of the game rules.
module tb_cable_launch_sequencer;
   localparam int MAXE = 60;
   localparam int COOL = 8;
   localparam int WW   = 3;
   localparam int VW   = 8;
   localparam int AUTO = 90;
`ifdef CABLE_AUTO_FIRE_EN
   localparam int AUTO_LAUNCHES = 1;
`else
   localparam int AUTO_LAUNCHES = 0;
`endif

   logic          clk = 1'b0;
   logic          resetN = 1'b1;
   logic          startOfFrame = 1'b0;
   logic          fire_btn = 1'b0;
   logic          isInCircular = 1'b0;
   logic          hit_object = 1'b0;
   logic          hit_border = 1'b0;
   logic [WW-1:0] object_weight = '0;
   logic [VW-1:0] object_value = '0;
   logic          launch_Cable, collision, frame_en, grabbed, deposit_pulse;
   logic [VW-1:0] deposit_value;
   logic [2:0]    seq_state;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cable_launch_sequencer #(
      .MAX_EXTEND_FRAMES(MAXE), .COOLDOWN_FRAMES(COOL), .WEIGHT_W(WW),
      .VALUE_W(VW), .AUTO_FIRE_FRAMES(AUTO)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire_btn(fire_btn),
      .isInCircular(isInCircular), .hit_object(hit_object), .hit_border(hit_border),
      .object_weight(object_weight), .object_value(object_value),
      .launch_Cable(launch_Cable), .collision(collision), .frame_en(frame_en),
      .grabbed(grabbed), .deposit_pulse(deposit_pulse), .deposit_value(deposit_value),
      .seq_state(seq_state)
   );

   // Reference model: phase number, frames seen in the current phase, payload.
   int m_phase, m_ext, m_ret, m_cool, m_idle, m_w, m_v, m_dep_val;
   bit m_grab, m_fire_prev, m_circ_prev;
   bit e_launch, e_coll, e_fen, e_dep;
   int tick = 0;
   bit rand_sof = 1'b0;
   int launches = 0, collisions = 0, deposits = 0;

   task automatic model_reset();
      m_phase = 0; m_ext = 0; m_ret = 0; m_cool = 0; m_idle = 0;
      m_w = 0; m_v = 0; m_dep_val = 0; m_grab = 0; m_fire_prev = 0; m_circ_prev = 0;
      e_launch = 0; e_coll = 0; e_fen = 0; e_dep = 0;
   endtask

   task automatic model_step();
      bit rise, crise;
      int nphase;
      rise  = fire_btn && !m_fire_prev;
      crise = isInCircular && !m_circ_prev;
      e_launch = 0; e_coll = 0; e_fen = 0; e_dep = 0;
      nphase = m_phase;
      case (m_phase)
         0: begin
            e_fen = startOfFrame;
            if (rise) begin
               m_idle = 0;
               if (isInCircular) nphase = 1;
            end
`ifdef CABLE_AUTO_FIRE_EN
            else if (isInCircular && startOfFrame) begin
               m_idle++;
               if (m_idle == AUTO) nphase = 1;
            end
`endif
            if (nphase == 1) begin e_launch = 1; m_ext = 0; end
         end
         1: begin
            e_fen = startOfFrame;
            if (startOfFrame) m_ext++;
            if (hit_object) begin
               m_grab = 1; m_w = int'(object_weight); m_v = int'(object_value); nphase = 2;
            end else if (hit_border || m_ext == MAXE) begin
               m_grab = 0; m_w = 0; nphase = 2;
            end
            if (nphase == 2) begin e_coll = 1; m_ret = 0; end
         end
         2: begin
            if (startOfFrame) begin
               m_ret++;
               e_fen = (m_ret % (m_w + 1)) == 0;
            end
            if (crise) begin
               if (m_grab) begin
                  nphase = 3; e_dep = 1; m_dep_val = m_v; m_grab = 0;
               end else begin
                  nphase = 4; m_cool = 0;
               end
            end
         end
         3: begin nphase = 4; m_cool = 0; end
         default: begin
            e_fen = startOfFrame;
            if (startOfFrame) m_cool++;
            if (m_cool >= COOL) begin nphase = 0; m_idle = 0; end
         end
      endcase
      m_phase = nphase;
      m_fire_prev = fire_btn;
      m_circ_prev = isInCircular;
   endtask

   task automatic check_outputs();
      vectors++;
      assert (seq_state === 3'(m_phase)) else begin
         miscompares++; $error("FAIL seq_state got %0d want %0d t=%0t", seq_state, m_phase, $time);
      end
      assert (launch_Cable === e_launch) else begin
         miscompares++; $error("FAIL launch_Cable got %b want %b t=%0t", launch_Cable, e_launch, $time);
      end
      assert (collision === e_coll) else begin
         miscompares++; $error("FAIL collision got %b want %b t=%0t", collision, e_coll, $time);
      end
      assert (frame_en === e_fen) else begin
         miscompares++; $error("FAIL frame_en got %b want %b t=%0t", frame_en, e_fen, $time);
      end
      assert (grabbed === m_grab) else begin
         miscompares++; $error("FAIL grabbed got %b want %b t=%0t", grabbed, m_grab, $time);
      end
      assert (deposit_pulse === e_dep) else begin
         miscompares++; $error("FAIL deposit_pulse got %b want %b t=%0t", deposit_pulse, e_dep, $time);
      end
      assert (deposit_value === VW'(m_dep_val)) else begin
         miscompares++; $error("FAIL deposit_value got %0d want %0d t=%0t", deposit_value, m_dep_val, $time);
      end
   endtask

   task automatic expect_eq(input string tag, input int got, input int want);
      vectors++;
      assert (got === want) else begin
         miscompares++; $error("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   // One clock: inputs are already set; sample outputs 1 time unit after the edge.
   task automatic step();
      if (rand_sof) startOfFrame = ($urandom_range(0, 3) == 0);
      else          startOfFrame = ((tick % 4) == 3);
      tick++;
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
      if (launch_Cable === 1'b1) launches++;
      if (collision === 1'b1) collisions++;
      if (deposit_pulse === 1'b1) deposits++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reset asserted between edges so the clear must be asynchronous to be seen.
   task automatic pulse_reset();
      #2;
      resetN = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      resetN = 1'b1;
   endtask

   initial begin
      int l0, c0, d0;
      #1;
      pulse_reset();

      // Launch on fire rise, single launch while held
      isInCircular = 1; run(3);
      fire_btn = 1; step();
      expect_eq("t1_launch", launch_Cable, 1);
      expect_eq("t1_state", seq_state, 1);
      run(3);
      expect_eq("t1_single_launch", launches, 1);

      // Grab weight 3 value 25, slow retract, deposit
      fire_btn = 0; isInCircular = 0; run(8);
      hit_object = 1; object_weight = 3; object_value = 25; step();
      hit_object = 0;
      expect_eq("t2_collision", collision, 1);
      expect_eq("t2_grabbed", grabbed, 1);
      run(40);
      isInCircular = 1; step();
      expect_eq("t2_dep_pulse", deposit_pulse, 1);
      expect_eq("t2_dep_value", deposit_value, 25);
      step();
      expect_eq("t2_cooldown", seq_state, 4);
      run(40);
      expect_eq("t2_back_swing", seq_state, 0);

      // Simultaneous object and border hit, weight 0
      fire_btn = 1; step();
      fire_btn = 0; isInCircular = 0; run(5);
      c0 = collisions;
      hit_object = 1; hit_border = 1; object_weight = 0; object_value = 10; step();
      hit_object = 0; hit_border = 0;
      expect_eq("t3_grabbed", grabbed, 1);
      run(20);
      expect_eq("t3_one_collision", collisions, c0 + 1);
      isInCircular = 1; step();
      expect_eq("t3_dep_value", deposit_value, 10);
      run(40);

      // Miss timeout, no deposit, cooldown back to swing
      fire_btn = 1; step();
      fire_btn = 0; isInCircular = 0;
      c0 = collisions;
      run(MAXE * 4 + 4);
      expect_eq("t4_timeout_collision", collisions, c0 + 1);
      expect_eq("t4_grabbed", grabbed, 0);
      d0 = deposits;
      isInCircular = 1; run(40);
      expect_eq("t4_no_deposit", deposits, d0);
      expect_eq("t4_swing", seq_state, 0);

      // Fire ignored in retract/cooldown; reset mid-retract with payload
      fire_btn = 1; step();
      fire_btn = 0; isInCircular = 0; run(3);
      hit_border = 1; step();
      hit_border = 0;
      l0 = launches;
      for (int i = 0; i < 10; i++) begin fire_btn = ~fire_btn; run(2); end
      isInCircular = 1; step();
      for (int i = 0; i < 10; i++) begin fire_btn = ~fire_btn; run(2); end
      expect_eq("t5_no_launch", launches, l0);
      fire_btn = 0; run(20);
      fire_btn = 1; step();
      fire_btn = 0; isInCircular = 0; run(3);
      hit_object = 1; object_weight = 5; object_value = 77; step();
      hit_object = 0; run(10);
      d0 = deposits;
      pulse_reset();
      expect_eq("t5_reset_state", seq_state, 0);
      expect_eq("t5_reset_grabbed", grabbed, 0);
      isInCircular = 1; run(10);
      expect_eq("t5_no_deposit", deposits, d0);

      // Idle swing: auto launch only when the option is built in
      l0 = launches;
      run(95 * 4);
      expect_eq("t6_auto_launch", launches, l0 + AUTO_LAUNCHES);

      // Random play
      rand_sof = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) fire_btn = ~fire_btn;
         if ($urandom_range(0, 15) == 0) isInCircular = ~isInCircular;
         hit_object = ($urandom_range(0, 19) == 0);
         hit_border = ($urandom_range(0, 29) == 0);
         object_weight = WW'($urandom);
         object_value = VW'($urandom);
         if ($urandom_range(0, 1499) == 0) pulse_reset();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
